mem_port_arbiter: RTL and testbench

Parametrised arbiter that lets NUM_PORTS cache clients (e.g. instruction cache and data cache) share one block-level memory.
- It generalises the fixed one-cache-per-memory pairing with an OR-combined stall into N-channel round-robin arbitration over a single memory port.
- It reproduces each client's existing busywait handshake, so no client needs to change.
- It produces the combined CPU stall signal.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block memory port among NUM_PORTS cache clients.
// Uncontended access takes memory latency + 3 cycles; clients stall on c_busywait until their RESP cycle.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_PORTS-1:0]          c_read,
  input  logic [NUM_PORTS-1:0]          c_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   c_address,
  input  logic [NUM_PORTS*DATA_W-1:0]   c_writedata,
  output logic [DATA_W-1:0]             c_readdata,
  output logic [NUM_PORTS-1:0]          c_busywait,
  output logic                          any_busy,
  output logic                          m_read,
  output logic                          m_write,
  output logic [ADDR_W-1:0]             m_address,
  output logic [DATA_W-1:0]             m_writedata,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_busywait
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     grant, rr_ptr, sel_idx, cand;
  logic                 sel_vld, take, done;
  logic [NUM_PORTS-1:0] req, resp_mask, req_elig;

  assign req = c_read | c_write;

  // The port being answered is masked in RESP so its still-high request is not re-granted.
  assign resp_mask  = (state == RESP) ? (NUM_PORTS'(1) << grant) : '0;
  assign req_elig   = req & ~resp_mask;
  assign c_busywait = req_elig;
  assign any_busy   = |c_busywait;

  // Search from rr_ptr+1 upwards; scanning downwards lets the nearest requester win.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (req_elig[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = ISSUE;
          take      = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!m_busywait) begin
          state_nxt = RESP;
          done      = 1'b1;
        end
      end
      RESP: begin
        if (sel_vld) begin
          state_nxt = ISSUE;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant       <= '0;
      rr_ptr      <= PTR_W'(NUM_PORTS - 1);
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      c_readdata  <= '0;
    end else begin
      if (take) begin
        grant       <= sel_idx;
        m_read      <= ~c_write[sel_idx];
        m_write     <= c_write[sel_idx];
        m_address   <= c_address[int'(sel_idx)*ADDR_W +: ADDR_W];
        m_writedata <= c_writedata[int'(sel_idx)*DATA_W +: DATA_W];
      end
      if (done) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
        rr_ptr  <= grant;
        if (!m_write) c_readdata <= m_readdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-port/32-bit instance and a 3-port/128-bit instance,
// each with a behavioural memory; expected accesses are queued and checked at each RESP.
module tb_mem_port_arbiter;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- instance A: 2 ports, 32-bit ----------------
  logic [1:0]  a_read, a_write, a_busy;
  logic [11:0] a_address;
  logic [63:0] a_writedata;
  logic [31:0] a_c_readdata, a_m_writedata, a_m_readdata;
  logic        a_any, a_m_read, a_m_write, a_m_busy;
  logic [5:0]  a_m_address;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(6), .DATA_W(32)) dut_a (
    .CLK(CLK), .RESET(RESET),
    .c_read(a_read), .c_write(a_write), .c_address(a_address), .c_writedata(a_writedata),
    .c_readdata(a_c_readdata), .c_busywait(a_busy), .any_busy(a_any),
    .m_read(a_m_read), .m_write(a_m_write), .m_address(a_m_address),
    .m_writedata(a_m_writedata), .m_readdata(a_m_readdata), .m_busywait(a_m_busy)
  );

  // ---------------- instance B: 3 ports, 128-bit ----------------
  logic [2:0]   b_read, b_write, b_busy;
  logic [17:0]  b_address;
  logic [383:0] b_writedata;
  logic [127:0] b_c_readdata, b_m_writedata, b_m_readdata;
  logic         b_any, b_m_read, b_m_write, b_m_busy;
  logic [5:0]   b_m_address;

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(6), .DATA_W(128)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .c_read(b_read), .c_write(b_write), .c_address(b_address), .c_writedata(b_writedata),
    .c_readdata(b_c_readdata), .c_busywait(b_busy), .any_busy(b_any),
    .m_read(b_m_read), .m_write(b_m_write), .m_address(b_m_address),
    .m_writedata(b_m_writedata), .m_readdata(b_m_readdata), .m_busywait(b_m_busy)
  );

  function automatic logic [31:0] pat_a(input logic [5:0] a);
    return (a == 6'h05) ? 32'hDEADBEEF : (32'hA5A50000 | {26'b0, a});
  endfunction

  function automatic logic [127:0] pat_b(input logic [5:0] a);
    return {32'h11110000 | {26'b0, a}, 32'h22220000 | {26'b0, a},
            32'h33330000 | {26'b0, a}, 32'h44440000 | {26'b0, a}};
  endfunction

  // ---------------- memory models ----------------
  // busywait rises with the request and stays high for LAT cycles; completion edge follows.
  localparam int LAT_A = 5;
  localparam int LAT_B = 2;

  typedef struct { bit wr; logic [5:0] addr; logic [31:0] wdata; } log_t;
  typedef struct { int port; bit wr; logic [5:0] addr; logic [31:0] data; } exp_t;
  typedef struct { int port; logic [127:0] data; } expb_t;

  logic [31:0]  mem_a [64];
  logic [127:0] mem_b [64];
  int           cnt_a, cnt_b;
  log_t         log_a [$];
  exp_t         exp_a [$];
  expb_t        exp_b [$];
  exp_t         mon_e;
  log_t         mon_l;

  assign a_m_busy     = (a_m_read || a_m_write) && (cnt_a < LAT_A);
  assign a_m_readdata = mem_a[a_m_address];
  assign b_m_busy     = (b_m_read || b_m_write) && (cnt_b < LAT_B);
  assign b_m_readdata = mem_b[b_m_address];

  always @(posedge CLK) begin
    if (RESET) begin
      cnt_a <= 0;
      for (int i = 0; i < 64; i++) mem_a[i] <= pat_a(6'(i));
    end else if (!(a_m_read || a_m_write)) begin
      cnt_a <= 0;
    end else if (cnt_a < LAT_A) begin
      cnt_a <= cnt_a + 1;
    end else begin
      if (a_m_write) mem_a[a_m_address] <= a_m_writedata;
      log_a.push_back('{a_m_write, a_m_address, a_m_writedata});
    end
  end

  always @(posedge CLK) begin
    if (RESET) begin
      cnt_b <= 0;
      for (int i = 0; i < 64; i++) mem_b[i] <= pat_b(6'(i));
    end else if (!(b_m_read || b_m_write)) begin
      cnt_b <= 0;
    end else if (cnt_b < LAT_B) begin
      cnt_b <= cnt_b + 1;
    end
  end

  // ---------------- scoreboard for instance A ----------------
  always @(negedge CLK) begin
    if (!RESET) begin
      for (int p = 0; p < 2; p++) begin
        if ((a_read[p] || a_write[p]) && !a_busy[p]) begin
          n_cmp++;
          if (exp_a.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: port %0d answered, nothing expected", p);
          end else begin
            mon_e = exp_a.pop_front();
            if (mon_e.port != p) begin
              n_bad++;
              $display("FAIL sb_port: answered port %0d, expected port %0d", p, mon_e.port);
            end
            n_cmp++;
            if (log_a.size() == 0) begin
              n_bad++;
              $display("FAIL sb_mem: port %0d answered without a memory completion", p);
            end else begin
              mon_l = log_a.pop_front();
              n_cmp++;
              if ({mon_l.wr, mon_l.addr} !== {mon_e.wr, mon_e.addr}) begin
                n_bad++;
                $display("FAIL sb_access: mem got wr=%0d addr=%h, expected wr=%0d addr=%h",
                         mon_l.wr, mon_l.addr, mon_e.wr, mon_e.addr);
              end
              if (mon_e.wr) begin
                n_cmp++;
                if (mon_l.wdata !== mon_e.data) begin
                  n_bad++;
                  $display("FAIL sb_wdata: mem got %h, expected %h", mon_l.wdata, mon_e.data);
                end
              end
            end
            if (!mon_e.wr) begin
              n_cmp++;
              if (a_c_readdata !== mon_e.data) begin
                n_bad++;
                $display("FAIL sb_rdata: port %0d got %h, expected %h", p, a_c_readdata, mon_e.data);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_a(input int p, input bit wr, input logic [5:0] addr, input logic [31:0] wd);
    a_read[p]               = !wr;
    a_write[p]              = wr;
    a_address[p*6 +: 6]     = addr;
    a_writedata[p*32 +: 32] = wd;
  endtask

  // Waits for port p's RESP cycle; releases the request afterwards unless hold is set.
  task automatic wait_resp(input int p, input bit hold, output int cycles,
                           output bit peer_ok, output bit busy_ok);
    bit found;
    found   = 1'b0;
    cycles  = 0;
    peer_ok = 1'b1;
    busy_ok = 1'b1;
    while (!found && cycles < 60) begin
      @(negedge CLK);
      cycles++;
      if (a_busy[1-p] !== 1'b1) peer_ok = 1'b0;
      if ((a_read[p] || a_write[p]) && !a_busy[p]) found = 1'b1;
      else if (a_any !== 1'b1) busy_ok = 1'b0;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL resp_timeout: port %0d unanswered after %0d cycles, expected a RESP", p, cycles);
    end else if (!hold) begin
      @(posedge CLK); #1;
      a_read[p]  = 1'b0;
      a_write[p] = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge CLK);
    n_cmp++;
    if ({a_m_read, a_m_write} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mreq: got %b, expected 00", {a_m_read, a_m_write});
    end
    n_cmp++;
    if (a_m_address !== 6'h00) begin
      n_bad++; $display("FAIL rst_maddr: got %h, expected 00", a_m_address);
    end
    n_cmp++;
    if (a_m_writedata !== 32'h0) begin
      n_bad++; $display("FAIL rst_mwdata: got %h, expected 0", a_m_writedata);
    end
    n_cmp++;
    if (a_c_readdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_rdata: got %h, expected 0", a_c_readdata);
    end
    n_cmp++;
    if ({a_busy, a_any} !== 3'b000) begin
      n_bad++; $display("FAIL rst_busy: got %b, expected 000", {a_busy, a_any});
    end
    n_cmp++;
    if ({b_c_readdata, b_m_read, b_m_write} !== 130'h0) begin
      n_bad++; $display("FAIL rst_b: rdata %h req %b, expected zeros", b_c_readdata, {b_m_read, b_m_write});
    end
  endtask

  task automatic test_contention;
    int cyc; bit pk, bk;
    @(posedge CLK); #1;
    drive_a(0, 1'b0, 6'h01, 32'h0);
    drive_a(1, 1'b0, 6'h02, 32'h0);
    exp_a.push_back('{0, 1'b0, 6'h01, pat_a(6'h01)});
    exp_a.push_back('{1, 1'b0, 6'h02, pat_a(6'h02)});
    wait_resp(0, 1'b0, cyc, pk, bk);
    n_cmp++;
    if (pk !== 1'b1) begin
      n_bad++; $display("FAIL t2_peer_busy: port1 busywait dropped during port0 access (got 0, expected 1)");
    end
    @(negedge CLK);
    n_cmp++;
    if (a_m_read !== 1'b1 || a_m_address !== 6'h02) begin
      n_bad++; $display("FAIL t2_next_issue: m_read=%b addr=%h, expected 1/02", a_m_read, a_m_address);
    end
    wait_resp(1, 1'b0, cyc, pk, bk);
  endtask

  task automatic test_round_robin;
    int cyc; bit pk, bk;
    @(posedge CLK); #1;
    drive_a(0, 1'b0, 6'h10, 32'h0);
    drive_a(1, 1'b0, 6'h20, 32'h0);
    for (int k = 0; k < 6; k++)
      exp_a.push_back('{k % 2, 1'b0, (k % 2) ? 6'h20 : 6'h10, pat_a((k % 2) ? 6'h20 : 6'h10)});
    for (int k = 0; k < 6; k++) begin
      wait_resp(k % 2, k < 4, cyc, pk, bk);
      n_cmp++;
      if (bk !== 1'b1) begin
        n_bad++; $display("FAIL t3_any_busy: access %0d saw any_busy 0 while pending, expected 1", k);
      end
    end
  endtask

  task automatic test_single_read;
    int cyc; bit pk, bk;
    @(posedge CLK); #1;
    drive_a(0, 1'b0, 6'h05, 32'h0);
    exp_a.push_back('{0, 1'b0, 6'h05, 32'hDEADBEEF});
    @(negedge CLK);
    n_cmp++;
    if (a_busy[0] !== 1'b1 || a_m_read !== 1'b0) begin
      n_bad++; $display("FAIL t1_req_cycle: busy=%b m_read=%b, expected 1/0", a_busy[0], a_m_read);
    end
    @(negedge CLK);
    n_cmp++;
    if (a_m_read !== 1'b1 || a_m_address !== 6'h05) begin
      n_bad++; $display("FAIL t1_issue: m_read=%b addr=%h, expected 1/05", a_m_read, a_m_address);
    end
    wait_resp(0, 1'b1, cyc, pk, bk);
    n_cmp++;
    if (cyc + 2 != 8) begin
      n_bad++; $display("FAIL t1_latency: RESP in access cycle %0d, expected 8", cyc + 2);
    end
    n_cmp++;
    if (a_c_readdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL t1_rdata: got %h, expected deadbeef", a_c_readdata);
    end
    // Request held past RESP starts a fresh access.
    exp_a.push_back('{0, 1'b0, 6'h05, 32'hDEADBEEF});
    @(negedge CLK);
    n_cmp++;
    if (a_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL t1_resp_len: busywait low 2 cycles (got 0, expected 1)");
    end
    wait_resp(0, 1'b0, cyc, pk, bk);
  endtask

  task automatic test_write_latch;
    int cyc; bit pk, bk;
    logic [31:0] old_rd;
    @(posedge CLK); #1;
    old_rd = a_c_readdata;
    drive_a(1, 1'b1, 6'h3F, 32'h12345678);
    exp_a.push_back('{1, 1'b1, 6'h3F, 32'h12345678});
    @(posedge CLK);
    @(posedge CLK); #1;
    a_address[6 +: 6]    = 6'h00;
    a_writedata[32 +: 32] = 32'h0;
    wait_resp(1, 1'b0, cyc, pk, bk);
    n_cmp++;
    if (a_c_readdata !== old_rd) begin
      n_bad++; $display("FAIL t4_rdata_kept: got %h, expected %h", a_c_readdata, old_rd);
    end
  endtask

  task automatic test_reset_mid_access;
    int cyc; bit pk, bk;
    @(posedge CLK); #1;
    drive_a(0, 1'b0, 6'h07, 32'h0);
    exp_a.push_back('{0, 1'b0, 6'h07, pat_a(6'h07)});
    wait_resp(0, 1'b0, cyc, pk, bk);
    @(posedge CLK); #1;
    drive_a(1, 1'b0, 6'h08, 32'h0);
    @(posedge CLK);
    @(posedge CLK); #1;
    n_cmp++;
    if (a_m_read !== 1'b1) begin
      n_bad++; $display("FAIL t5_inflight: m_read=%b before reset, expected 1", a_m_read);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if ({a_m_read, a_m_write} !== 2'b00) begin
      n_bad++; $display("FAIL t5_drop: m_read/m_write=%b after reset edge, expected 00", {a_m_read, a_m_write});
    end
    RESET     = 1'b0;
    a_read[1] = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (a_m_read !== 1'b0 || a_any !== 1'b0) begin
      n_bad++; $display("FAIL t5_idle: m_read=%b any_busy=%b, expected 0/0", a_m_read, a_any);
    end
    @(posedge CLK); #1;
    drive_a(0, 1'b0, 6'h09, 32'h0);
    drive_a(1, 1'b0, 6'h0A, 32'h0);
    exp_a.push_back('{0, 1'b0, 6'h09, pat_a(6'h09)});
    exp_a.push_back('{1, 1'b0, 6'h0A, pat_a(6'h0A)});
    wait_resp(0, 1'b0, cyc, pk, bk);
    wait_resp(1, 1'b0, cyc, pk, bk);
  endtask

  task automatic test_three_port_wrap;
    expb_t e;
    int    guard;
    int    hit;
    for (int r = 0; r < 2; r++) begin
      @(posedge CLK); #1;
      if (r == 0) begin
        b_read[2] = 1'b1; b_address[12 +: 6] = 6'h03;
        exp_b.push_back('{2, pat_b(6'h03)});
      end else begin
        b_read[1] = 1'b1; b_address[6 +: 6]  = 6'h04;
        b_read[2] = 1'b1; b_address[12 +: 6] = 6'h05;
        exp_b.push_back('{1, pat_b(6'h04)});
        exp_b.push_back('{2, pat_b(6'h05)});
      end
      guard = 0;
      while (exp_b.size() > 0 && guard < 100) begin
        @(negedge CLK);
        guard++;
        hit = -1;
        for (int p = 0; p < 3; p++)
          if (b_read[p] && !b_busy[p]) hit = p;
        if (hit >= 0) begin
          e = exp_b.pop_front();
          n_cmp++;
          if (hit != e.port) begin
            n_bad++; $display("FAIL t6_order: answered port %0d, expected port %0d", hit, e.port);
          end
          n_cmp++;
          if (b_c_readdata !== e.data) begin
            n_bad++; $display("FAIL t6_rdata: got %h, expected %h", b_c_readdata, e.data);
          end
          @(posedge CLK); #1;
          b_read[hit] = 1'b0;
        end
      end
      if (guard >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL t6_timeout: %0d accesses unanswered, expected 0", exp_b.size());
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    RESET       = 1'b1;
    a_read      = '0; a_write     = '0;
    a_address   = '0; a_writedata = '0;
    b_read      = '0; b_write     = '0;
    b_address   = '0; b_writedata = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    test_reset;
    test_contention;
    test_round_robin;
    test_single_read;
    test_write_latch;
    test_reset_mid_access;
    test_three_port_wrap;

    repeat (3) @(posedge CLK);
    n_cmp++;
    if (exp_a.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: %0d expected accesses never answered, expected 0", exp_a.size());
    end
    n_cmp++;
    if (log_a.size() != 0) begin
      n_bad++; $display("FAIL mem_leftover: %0d memory completions unclaimed, expected 0", log_a.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
    $fatal(1);
  end

endmodule
